vending_machine_multi: RTL
==========================

Name: vending_machine_multi

Overview:
Parametrised next-generation vending controller with NUM_ITEMS products, per-item prices, per-item stock tracking, credit accumulation, cancel/timeout refund and an exact returned-change amount. Sits between the coin acceptor front-end (single-cycle coin pulses) and the dispenser/return-hopper drivers. All outputs are registered. Single clock domain.

Parameters:
NUM_ITEMS, 4, number of products (2..16)
SEL_W, 2, selection index width; must satisfy 2**SEL_W >= NUM_ITEMS
CREDIT_W, 8, credit, price and refund width
PRICE_LIST, {8'd20,8'd15,8'd10,8'd5}, packed NUM_ITEMS x CREDIT_W prices; item i at bits [i*CREDIT_W +: CREDIT_W]
MAX_CREDIT, 100, highest credit accepted
TIMEOUT, 16, idle cycles in CREDIT before auto-refund
STOCK_W, 4, per-item stock counter width
INIT_STOCK, 3, stock of every item after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
coin_5  in  1  one-cycle pulse, 5-unit coin
coin_10  in  1  one-cycle pulse, 10-unit coin
sel  in  SEL_W  item index, qualified by sel_valid
sel_valid  in  1  one-cycle selection request
cancel  in  1  one-cycle refund request
restock  in  1  one-cycle pulse, add one unit to item restock_sel
restock_sel  in  SEL_W  item to restock
dispense  out  NUM_ITEMS  one-hot, one-cycle dispense pulse
change  out  1  high with dispense when remaining credit > 0
rtn  out  CREDIT_W  refund amount, valid when rtn_valid
rtn_valid  out  1  one-cycle refund strobe
credit  out  CREDIT_W  current credit
deny  out  1  one-cycle pulse: selection refused
coin_reject  out  1  one-cycle pulse: coin not accepted, returned physically
sold_out  out  NUM_ITEMS  bit i high when stock[i]==0
busy  out  1  high in VEND and RETURN

Behaviour:
- Reset (rst high at clk edge): state=IDLE; credit=0; all stock=INIT_STOCK; timer=0; dispense, change, rtn, rtn_valid, deny, coin_reject=0; sold_out per INIT_STOCK. rst overrides all inputs, including mid-vend; no dispense or refund is issued.
- States: IDLE, CREDIT, VEND, RETURN.
- Coin value per cycle = 5*coin_5 + 10*coin_10; both high = 15. Accepted only in IDLE/CREDIT and only if credit+value <= MAX_CREDIT (compute at CREDIT_W+1 bits). Otherwise credit is unchanged and coin_reject pulses the next cycle. Both coins in one overflowing cycle: both rejected.
- IDLE: accepted coin -> CREDIT. sel_valid/cancel in IDLE are ignored; no deny is issued.
- CREDIT: timer reloads to 0 on every accepted coin and otherwise increments. Priority order: cancel > sel_valid > timeout.
  - cancel -> RETURN.
  - sel_valid: deny if sel >= NUM_ITEMS, sold_out[sel], or pre-coin credit < price[sel]. Otherwise latch sel and go to VEND. Deny leaves the FSM in CREDIT and reloads the timer.
  - timer == TIMEOUT-1 with no accepted coin that cycle -> RETURN.
  - A coin accepted in the same cycle as a granted selection is added and carried into VEND.
- VEND (one cycle): dispense[sel_latched]=1; credit -= price; stock[sel_latched]--. change = (new credit != 0). Next state is RETURN if new credit != 0, else IDLE.
- RETURN (one cycle): rtn=credit, rtn_valid=1, credit=0. Next state is IDLE.
- Latencies: dispense follows a granted sel_valid by exactly 1 cycle. rtn_valid follows dispense by 1 cycle, or follows cancel/timeout by 1 cycle. deny follows sel_valid by 1 cycle.
- rtn holds its last value; it is only meaningful with rtn_valid.
- Restock: accepted in any state. stock[restock_sel] increments, saturating at 2**STOCK_W-1; out-of-range restock_sel is ignored. Restock and vend decrement on the same item in the same cycle: net stock unchanged.
- Pulsed outputs are high for exactly one cycle per event.

Optional Feature:
SALES_AUDIT_EN: when defined, adds output ports sales_total [15:0] (sum of prices vended, saturating at 16'hFFFF) and vend_count [15:0] (number of vends, saturating). Both update in the VEND cycle and reset to 0. When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, coin_10, coin_10, sel=1 -> dispense=4'b0010 one cycle later, change=1; next cycle rtn=10 with rtn_valid=1; credit=0; state IDLE.
- coin_5, sel=2 (price 15) -> deny pulse, credit stays 5; then no input for 16 cycles -> rtn=5 with rtn_valid=1.
- Credit 95, coin_10 -> coin_reject=1, credit stays 95; then cancel and sel_valid in the same cycle -> no dispense, rtn=95.
- With INIT_STOCK=1: buy item 0 twice (exact 5 each time) -> second selection denied, sold_out[0]=1. restock with restock_sel=0 -> sold_out[0]=0 and the third purchase succeeds.
- rst asserted in the cycle the FSM is in VEND -> no rtn_valid afterwards; credit=0; stock back at INIT_STOCK.
- SALES_AUDIT_EN: vend items 0, 1, 3 with exact credit -> vend_count=3, sales_total=35.

Source files
------------

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: credit, per-item stock, cancel/timeout refund.
// Optional SALES_AUDIT_EN adds sales_total/vend_count audit outputs.
module vending_machine_multi #(
  parameter int NUM_ITEMS = 4,
  parameter int SEL_W = 2,
  parameter int CREDIT_W = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST =
    {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int MAX_CREDIT = 100,
  parameter int TIMEOUT = 16,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coin_5,
  input  logic                 coin_10,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 sel_valid,
  input  logic                 cancel,
  input  logic                 restock,
  input  logic [SEL_W-1:0]     restock_sel,
  output logic [NUM_ITEMS-1:0] dispense,
  output logic                 change,
  output logic [CREDIT_W-1:0]  rtn,
  output logic                 rtn_valid,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 deny,
  output logic                 coin_reject,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
`ifdef SALES_AUDIT_EN
  ,
  output logic [15:0]          sales_total,
  output logic [15:0]          vend_count
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_RETURN = 2'd3;

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CREDIT_W:0] V5 = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W:0] V10 = (CREDIT_W+1)'(10);
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [SEL_W:0] NI = (SEL_W+1)'(NUM_ITEMS);
  localparam logic [STOCK_W-1:0] STK_MAX = '1;
  localparam logic [STOCK_W-1:0] STK_INIT = STOCK_W'(INIT_STOCK);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [TMR_W-1:0]    timer;
  logic [TMR_W-1:0]    timer_nxt;
  logic [STOCK_W-1:0]  stock [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_nxt [NUM_ITEMS];

  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_any;
  logic                coin_ok;
  logic [CREDIT_W-1:0] credit_acc;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [CREDIT_W-1:0] credit_left;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_in;
  logic                sel_empty;
  logic                grant;
  logic                deny_nxt;
  logic                timeout;
  logic                refund;
  logic [CREDIT_W-1:0] rtn_nxt;
  logic [NUM_ITEMS-1:0] dispense_nxt;
  logic [NUM_ITEMS-1:0] sold_nxt;

  // Coin valuation and acceptance against the credit ceiling
  always_comb begin
    coin_val = (coin_5 ? V5 : '0) + (coin_10 ? V10 : '0);
    coin_any = coin_5 | coin_10;
    credit_sum = {1'b0, credit} + coin_val;
    coin_ok = coin_any &&
              (state == S_IDLE || state == S_CREDIT) &&
              (credit_sum <= MAX_C);
    credit_acc = coin_ok ? credit_sum[CREDIT_W-1:0] : credit;
  end

  // Price and availability of the requested item
  always_comb begin
    sel_price = '0;
    sel_empty = 1'b1;
    sel_in = ({1'b0, sel} < NI);
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_price = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        sel_empty = (stock[i] == '0);
      end
    end
  end

  // Selection decision, timeout and refund conditions in CREDIT
  always_comb begin
    grant = (state == S_CREDIT) && !cancel && sel_valid &&
            sel_in && !sel_empty && (credit >= sel_price);
    deny_nxt = (state == S_CREDIT) && !cancel && sel_valid && !grant;
    timeout = (state == S_CREDIT) && !cancel && !sel_valid &&
              !coin_ok && (timer == TMR_LAST);
    credit_left = credit_acc - sel_price;
    refund = 1'b0;
    rtn_nxt = rtn;
    if (state == S_CREDIT && (cancel || timeout)) begin
      refund = 1'b1;
      rtn_nxt = credit_acc;
    end else if (state == S_VEND && credit != '0) begin
      refund = 1'b1;
      rtn_nxt = credit;
    end
  end

  // Next state, credit and idle timer
  always_comb begin
    state_nxt = state;
    credit_nxt = credit;
    timer_nxt = '0;
    unique case (state)
      S_IDLE: begin
        credit_nxt = credit_acc;
        if (coin_ok) state_nxt = S_CREDIT;
      end
      S_CREDIT: begin
        credit_nxt = credit_acc;
        if (cancel || timeout) begin
          state_nxt = S_RETURN;
          credit_nxt = '0;
        end else if (grant) begin
          state_nxt = S_VEND;
          credit_nxt = credit_left;
        end else if (!(coin_ok || sel_valid)) begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_VEND: begin
        credit_nxt = '0;
        state_nxt = (credit != '0) ? S_RETURN : S_IDLE;
      end
      S_RETURN: begin
        credit_nxt = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        credit_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Per-item stock update: vend decrement, saturating restock
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      logic inc;
      logic dec;
      inc = restock && (restock_sel == SEL_W'(i));
      dec = grant && (sel == SEL_W'(i));
      dispense_nxt[i] = dec;
      stock_nxt[i] = stock[i];
      if (inc && dec) stock_nxt[i] = stock[i];
      else if (dec) stock_nxt[i] = stock[i] - 1'b1;
      else if (inc && stock[i] != STK_MAX)
        stock_nxt[i] = stock[i] + 1'b1;
      sold_nxt[i] = (stock_nxt[i] == '0);
    end
  end

  // State, credit, stock and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      credit <= '0;
      timer <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STK_INIT;
      dispense <= '0;
      change <= 1'b0;
      rtn <= '0;
      rtn_valid <= 1'b0;
      deny <= 1'b0;
      coin_reject <= 1'b0;
      sold_out <= {NUM_ITEMS{STK_INIT == '0}};
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      credit <= credit_nxt;
      timer <= timer_nxt;
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= stock_nxt[i];
      dispense <= dispense_nxt;
      change <= grant && (credit_left != '0);
      rtn <= rtn_nxt;
      rtn_valid <= refund;
      deny <= deny_nxt;
      coin_reject <= coin_any && !coin_ok;
      sold_out <= sold_nxt;
      busy <= (state_nxt == S_VEND) || (state_nxt == S_RETURN);
    end
  end

`ifdef SALES_AUDIT_EN
  logic [16:0] total_sum;
  logic [16:0] count_sum;

  // Saturating sums for the audit counters
  always_comb begin
    total_sum = {1'b0, sales_total} + 17'(sel_price);
    count_sum = {1'b0, vend_count} + 17'd1;
  end

  // Audit counters advance together with the vend
  always_ff @(posedge clk) begin
    if (rst) begin
      sales_total <= '0;
      vend_count <= '0;
    end else if (grant) begin
      sales_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
      vend_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end
`else
  // Audit counters are not built in this configuration
`endif

endmodule
